img_buf_row_writer: RTL and testbench

- Writer front-end for the 512-row x 3072-bit image buffer.
- Accepts a 32-bit word stream from the CPU/DMA side with a valid/ready handshake and packs 96 words into one 3072-bit row.
- Commits each packed row to the buffer write port (we/waddr/wdata), starting at a programmable row and continuing for a programmable row count.
- Sits between the image coprocessor's load path and the buffer.

---
 rtl/img_buf_pkg.sv | 20 ++
 rtl/img_buf_row_writer_if.sv | 42 ++++
 rtl/img_row_packer.sv | 59 +++++
 rtl/img_buf_row_writer.sv | 167 ++++++++++++++++
 tb/tb_img_buf_row_writer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_buf_pkg.sv
// Shared constants and types for the image-buffer row writer.
// Contents:
//   IMG_ROW_W, IMG_ROWS, IMG_ADDR_W, IMG_WORD_W, IMG_WORDS_PER_ROW
//   img_wr_state_t : writer FSM state encoding
package img_buf_pkg;

  localparam int IMG_ROW_W         = 3072;
  localparam int IMG_ROWS          = 512;
  localparam int IMG_ADDR_W        = 9;
  localparam int IMG_WORD_W        = 32;
  localparam int IMG_WORDS_PER_ROW = IMG_ROW_W / IMG_WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_FINISH = 2'd3
  } img_wr_state_t;

endpackage

// File: rtl/img_buf_row_writer_if.sv
// Bus bundle for the image-buffer row writer: the inbound word stream
// (valid/ready) plus the outbound buffer write port.
// Modports:
//   slave  : the writer (consumes the stream, drives the buffer port)
//   master : the environment (drives the stream, observes the buffer port)
// Signals:
//   in_valid, in_data, in_ready         : word stream handshake
//   buf_we, buf_waddr, buf_wdata        : buffer row write port
interface img_buf_row_writer_if
  import img_buf_pkg::*;
#(
  parameter int WORD_W = IMG_WORD_W,
  parameter int ROW_W  = IMG_ROW_W,
  parameter int ADDR_W = IMG_ADDR_W
) ();

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [ROW_W-1:0]  buf_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output buf_we,
    output buf_waddr,
    output buf_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  buf_we,
    input  buf_waddr,
    input  buf_wdata
  );

endinterface

// File: rtl/img_row_packer.sv
// Packs a stream of WORD_W-bit words into one ROW_W-bit row.
// Word k of a row lands in bits [WORD_W*k +: WORD_W].
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart packing at word 0 (pack contents left as-is)
//   accept     : a word is taken this cycle
//   word       : the word being taken
//   row_full   : this accept completes the row (combinational)
//   row_data   : the row including the word being accepted this cycle,
//                so the caller can capture a complete row on the last edge
module img_row_packer #(
  parameter int WORD_W = 32,
  parameter int ROW_W  = 3072
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [WORD_W-1:0] word,
  output logic              row_full,
  output logic [ROW_W-1:0]  row_data
);

  localparam int WORDS = ROW_W / WORD_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [ROW_W-1:0] pack_q, pack_d;

  // Each word slot has its own load enable keyed on the word counter.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_slot
    assign pack_d[gi*WORD_W +: WORD_W] =
      (accept && (word_cnt_q == CNT_W'(gi))) ? word : pack_q[gi*WORD_W +: WORD_W];
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (clear) begin
      word_cnt_d = '0;
    end else if (accept) begin
      word_cnt_d = (word_cnt_q == LAST) ? '0 : word_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      pack_q     <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      pack_q     <= pack_d;
    end
  end

  assign row_full = accept && (word_cnt_q == LAST);
  assign row_data = pack_d;

endmodule

// File: rtl/img_buf_row_writer.sv
// Writer front-end for the 512-row x 3072-bit image buffer.
// Packs 96 inbound 32-bit words per row and commits each row to the buffer
// write port, starting at base_row for num_rows rows (clamped to 512),
// wrapping the row address modulo 512.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle transfer start pulse (ignored while busy)
//   base_row   : first row to write, sampled on start
//   num_rows   : row count 0..512 (larger values clamp), sampled on start
//   busy       : high outside IDLE
//   done       : one-cycle pulse in the FINISH state
//   cksum      : (only with IMG_WR_CKSUM_EN) 16-bit wrap-around sum of the
//                low and high halves of every accepted word
//   bus        : stream in / buffer write port (img_buf_row_writer_if.slave)
// Optional build macro: IMG_WR_CKSUM_EN
module img_buf_row_writer
  import img_buf_pkg::*;
#(
  parameter int WORD_W = IMG_WORD_W,
  parameter int ROW_W  = IMG_ROW_W,
  parameter int ADDR_W = IMG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_row,
  input  logic [ADDR_W:0]   num_rows,
  output logic              busy,
  output logic              done,
`ifdef IMG_WR_CKSUM_EN
  output logic [15:0]       cksum,
`endif
  img_buf_row_writer_if.slave bus
);

  localparam logic [ADDR_W:0] MAX_ROWS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_ROW  = {{ADDR_W{1'b0}}, 1'b1};

  img_wr_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   rows_q, rows_d;
  logic [ADDR_W:0]   row_cnt_q, row_cnt_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W-1:0] buf_waddr_q, buf_waddr_d;
  logic [ROW_W-1:0]  buf_wdata_q, buf_wdata_d;

  logic              accept;
  logic              pack_clear;
  logic              row_full;
  logic [ROW_W-1:0]  row_data;
  logic [ADDR_W:0]   rows_clamped;
  logic [ADDR_W:0]   row_cnt_inc;

  assign rows_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
  assign row_cnt_inc  = row_cnt_q + ONE_ROW;
  assign accept       = bus.in_valid && (state_q == ST_FILL);
  assign pack_clear   = (state_q == ST_IDLE) && start;

  img_row_packer #(
    .WORD_W (WORD_W),
    .ROW_W  (ROW_W)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pack_clear),
    .accept   (accept),
    .word     (bus.in_data),
    .row_full (row_full),
    .row_data (row_data)
  );

  // The write-port registers load on the edge that accepts the last word,
  // so buf_we is high exactly during the COMMIT cycle and address/data hold
  // their values until the next row completes.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    rows_d      = rows_q;
    row_cnt_d   = row_cnt_q;
    buf_we_d    = 1'b0;
    buf_waddr_d = buf_waddr_q;
    buf_wdata_d = buf_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d    = base_row;
          rows_d    = rows_clamped;
          row_cnt_d = '0;
          state_d   = (rows_clamped == '0) ? ST_FINISH : ST_FILL;
        end
      end
      ST_FILL: begin
        if (row_full) begin
          buf_we_d    = 1'b1;
          // Truncation to ADDR_W bits provides the modulo-512 wrap.
          buf_waddr_d = base_q + row_cnt_q[ADDR_W-1:0];
          buf_wdata_d = row_data;
          state_d     = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        row_cnt_d = row_cnt_inc;
        state_d   = (row_cnt_inc < rows_q) ? ST_FILL : ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      rows_q      <= '0;
      row_cnt_q   <= '0;
      buf_we_q    <= 1'b0;
      buf_waddr_q <= '0;
      buf_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      rows_q      <= rows_d;
      row_cnt_q   <= row_cnt_d;
      buf_we_q    <= buf_we_d;
      buf_waddr_q <= buf_waddr_d;
      buf_wdata_q <= buf_wdata_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.buf_we    = buf_we_q;
  assign bus.buf_waddr = buf_waddr_q;
  assign bus.buf_wdata = buf_wdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FINISH);

`ifdef IMG_WR_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  // Only cleared by an accepted start, so the final sum stays visible
  // after done until the next transfer begins.
  always_comb begin
    cksum_d = cksum_q;
    if (pack_clear) begin
      cksum_d = '0;
    end else if (accept) begin
      cksum_d = cksum_q + bus.in_data[15:0] + bus.in_data[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_img_buf_row_writer.sv
// Directed bench for img_buf_row_writer: single row, address wrap, random
// stalls, zero/clamped row counts, start while busy, reset mid-transfer,
// restart after reset, and the optional checksum (IMG_WR_CKSUM_EN).
module tb_img_buf_row_writer;
  import img_buf_pkg::*;

  typedef struct {
    logic [8:0]    addr;
    logic [3071:0] data;
    int            cyc;
    int            acc;
    logic          rdy;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] base_row = '0;
  logic [9:0] num_rows = '0;
  logic       busy;
  logic       done;
`ifdef IMG_WR_CKSUM_EN
  logic [15:0] cksum;
`endif

  img_buf_row_writer_if bus ();

  img_buf_row_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_row (base_row),
    .num_rows (num_rows),
    .busy     (busy),
    .done     (done),
`ifdef IMG_WR_CKSUM_EN
    .cksum    (cksum),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  vec_cnt = 0;
  int  miscmp = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  last_acc = 0;
  wr_t wr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.buf_we) begin
        wr_t e;
        e.addr = bus.buf_waddr;
        e.data = bus.buf_wdata;
        e.cyc  = cyc;
        e.acc  = last_acc;
        e.rdy  = bus.in_ready;
        wr_q.push_back(e);
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      // Inputs are stable here; this pair is what the next edge samples.
      if (bus.in_valid && bus.in_ready) last_acc = cyc + 1;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [3071:0] exp_row(input logic [31:0] seed, input int r);
    logic [3071:0] row;
    for (int j = 0; j < 96; j++) row[j*32 +: 32] = seed + 32'(r * 96 + j);
    return row;
  endfunction

  int start_cyc = 0;

  task automatic do_start(input logic [8:0] b, input logic [9:0] n);
    tick();
    start = 1'b1; base_row = b; num_rows = n;
    start_cyc = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  // Sends n_words words seed+k; optional pseudo-random stalls and a start
  // pulse issued when word pulse_at is being offered.
  task automatic stream(input int n_words, input logic [31:0] seed, input int stall_pct,
                        input int pulse_at, input logic [8:0] pb, input logic [9:0] pn);
    int   k = 0;
    int   guard = 0;
    logic pulsed = 1'b0;
    while (k < n_words) begin
      tick();
      start = 1'b0;
      if (k == pulse_at && !pulsed) begin
        start = 1'b1; base_row = pb; num_rows = pn; pulsed = 1'b1;
      end
      if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = seed + 32'(k);
        if (bus.in_ready) k++;
      end
      guard++;
      if (guard > n_words * 4 + 1000) begin
        chk("stream_timeout", 64'(k), 64'(n_words));
        break;
      end
    end
    tick();
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base_cnt, input int bound);
    int i = 0;
    while (done_cnt == base_cnt && i < bound) begin
      tick();
      i++;
    end
    if (done_cnt == base_cnt) chk("done_timeout", 64'(done_cnt), 64'(base_cnt + 1));
  endtask

  task automatic check_rows(input int first, input int n, input logic [8:0] base,
                            input logic [31:0] seed);
    for (int r = 0; r < n; r++) begin
      logic [8:0] a;
      if (first + r >= wr_q.size()) begin
        chk("row_missing", 64'(wr_q.size()), 64'(first + n));
        break;
      end
      a = base + 9'(r);
      chk("row_addr", 64'(wr_q[first + r].addr), 64'(a));
      chk("row_data", 64'(wr_q[first + r].data == exp_row(seed, r)), 64'd1);
    end
  endtask

  initial begin
    int w0, d0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_buf_we", 64'(bus.buf_we), 64'd0);
    chk("rst_waddr", 64'(bus.buf_waddr), 64'd0);
    chk("rst_wdata_zero", 64'(bus.buf_wdata == '0), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single row at base 5, words 1..96
    w0 = wr_q.size(); d0 = done_cnt;
    do_start(9'd5, 10'd1);
    chk("single_busy", 64'(busy), 64'd1);
    stream(96, 32'd1, 0, -1, '0, '0);
    wait_done(d0, 300);
    chk("single_nwr", 64'(wr_q.size() - w0), 64'd1);
    if (wr_q.size() > w0) begin
      chk("single_addr", 64'(wr_q[w0].addr), 64'd5);
      chk("single_w0", 64'(wr_q[w0].data[31:0]), 64'd1);
      chk("single_w95", 64'(wr_q[w0].data[3071:3040]), 64'd96);
      chk("single_we_lat", 64'(wr_q[w0].cyc), 64'(wr_q[w0].acc));
      chk("single_rdy_commit", 64'(wr_q[w0].rdy), 64'd0);
      chk("single_done_lat", 64'(done_cyc), 64'(wr_q[w0].cyc + 1));
    end
    check_rows(w0, 1, 9'd5, 32'd1);
    tick();
    chk("single_idle_busy", 64'(busy), 64'd0);
    chk("single_hold_addr", 64'(bus.buf_waddr), 64'd5);

    // Address wrap 510,511,0,1 at 97 cycles per row
    w0 = wr_q.size(); d0 = done_cnt;
    do_start(9'd510, 10'd4);
    stream(384, 32'h0000_1000, 0, -1, '0, '0);
    wait_done(d0, 300);
    chk("wrap_nwr", 64'(wr_q.size() - w0), 64'd4);
    check_rows(w0, 4, 9'd510, 32'h0000_1000);
    for (int r = 1; r < 4; r++)
      if (w0 + r < wr_q.size())
        chk("wrap_spacing", 64'(wr_q[w0 + r].cyc - wr_q[w0 + r - 1].cyc), 64'd97);

    // Random stalls, 2 rows
    w0 = wr_q.size(); d0 = done_cnt;
    do_start(9'd40, 10'd2);
    stream(192, 32'hA500_0000, 45, -1, '0, '0);
    wait_done(d0, 300);
    chk("stall_nwr", 64'(wr_q.size() - w0), 64'd2);
    check_rows(w0, 2, 9'd40, 32'hA500_0000);

    // num_rows = 0
    w0 = wr_q.size(); d0 = done_cnt;
    do_start(9'd7, 10'd0);
    repeat (5) tick();
    chk("zero_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("zero_done_lat", 64'(done_cyc), 64'(start_cyc));
    chk("zero_nwr", 64'(wr_q.size() - w0), 64'd0);

    // num_rows = 600 clamps to 512
    w0 = wr_q.size(); d0 = done_cnt;
    do_start(9'd3, 10'd600);
    stream(512 * 96, 32'h0100_0000, 0, -1, '0, '0);
    wait_done(d0, 300);
    chk("clamp_nwr", 64'(wr_q.size() - w0), 64'd512);
    check_rows(w0, 512, 9'd3, 32'h0100_0000);

    // start pulsed mid-transfer is ignored
    w0 = wr_q.size(); d0 = done_cnt;
    do_start(9'd20, 10'd2);
    stream(192, 32'h0C00_0000, 0, 30, 9'd100, 10'd5);
    wait_done(d0, 300);
    repeat (20) tick();
    chk("midstart_nwr", 64'(wr_q.size() - w0), 64'd2);
    chk("midstart_done", 64'(done_cnt - d0), 64'd1);
    chk("midstart_busy", 64'(busy), 64'd0);
    check_rows(w0, 2, 9'd20, 32'h0C00_0000);

    // Reset after word 50 of row 0
    w0 = wr_q.size(); d0 = done_cnt;
    do_start(9'd7, 10'd1);
    stream(50, 32'h0D00_0000, 0, -1, '0, '0);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("arst_waddr", 64'(bus.buf_waddr), 64'd0);
    chk("arst_wdata_zero", 64'(bus.buf_wdata == '0), 64'd1);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (150) tick();
    chk("arst_nwr", 64'(wr_q.size() - w0), 64'd0);
    chk("arst_ndone", 64'(done_cnt - d0), 64'd0);

    // Clean transfer after reset
    w0 = wr_q.size(); d0 = done_cnt;
    do_start(9'd9, 10'd1);
    stream(96, 32'h0E00_0000, 0, -1, '0, '0);
    wait_done(d0, 300);
    chk("post_rst_nwr", 64'(wr_q.size() - w0), 64'd1);
    check_rows(w0, 1, 9'd9, 32'h0E00_0000);

`ifdef IMG_WR_CKSUM_EN
    // Checksum: 96 words of 0x00010002 sum to 0x0120
    begin
      int k = 0;
      d0 = done_cnt;
      do_start(9'd0, 10'd1);
      chk("cksum_clear", 64'(cksum), 64'd0);
      while (k < 96) begin
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0001_0002;
        if (bus.in_ready) k++;
      end
      tick();
      bus.in_valid = 1'b0;
      wait_done(d0, 300);
      chk("cksum_final", 64'(cksum), 64'h0120);
      repeat (3) tick();
      chk("cksum_hold", 64'(cksum), 64'h0120);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
